// File: rtl/vram_ctrl_pkg.sv
// Shared VRAM geometry, clear value and controller state encoding.
package vram_ctrl_pkg;

    localparam int unsigned VRAM_ADDR_WIDTH = 11;
    localparam int unsigned VRAM_DATA_WIDTH = 2;
    localparam int unsigned VRAM_DEPTH      = 2048;
    localparam logic [VRAM_DATA_WIDTH-1:0] CLS_VAL = VRAM_DATA_WIDTH'(0);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } vram_state_t;

endpackage

// File: rtl/vram_ctrl.sv
// VRAM arbiter: scanout reads, draw-engine read/write and the clear-screen sequencer
// share one dual-port 2048x2 VRAM instantiated outside this block.
module vram_ctrl
    import vram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = VRAM_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = VRAM_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VAL = DATA_WIDTH'(CLS_VAL)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cls_req,
    output logic                  cls_busy,
    output logic                  cls_done,
    input  logic                  scan_req,
    input  logic [ADDR_WIDTH-1:0] scan_addr,
    output logic [DATA_WIDTH-1:0] scan_q,
    output logic                  scan_q_valid,
    input  logic                  draw_req,
    input  logic                  draw_we,
    input  logic [ADDR_WIDTH-1:0] draw_addr,
    input  logic [DATA_WIDTH-1:0] draw_d,
    output logic                  draw_gnt,
    output logic [DATA_WIDTH-1:0] draw_q,
    output logic                  draw_q_valid,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_d
);

    // One extra bit so termination is a full-count compare, never a wrap to zero.
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'((2 ** ADDR_WIDTH) - 1);

    vram_state_t      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             last_write;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            cls_done     <= 1'b0;
            scan_q_valid <= 1'b0;
            draw_q_valid <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            cls_done     <= last_write;
            scan_q_valid <= scan_req;
            draw_q_valid <= draw_gnt & ~draw_we;
        end
    end

    // Clear owns the write port; draw is granted only when idle and the read port is free.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        last_write = 1'b0;
        draw_gnt   = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = draw_addr;
        mem_d      = draw_d;
        case (state)
            ST_IDLE: begin
                draw_gnt = draw_req & (draw_we | ~scan_req);
                mem_we   = draw_gnt & draw_we;
                if (cls_req) begin
                    state_nxt = ST_CLEAR;
                    cnt_nxt   = '0;
                end
            end
            ST_CLEAR: begin
                // Reset aborts the sequence in the very cycle it is asserted.
                mem_we    = ~rst;
                mem_waddr = cnt[ADDR_WIDTH-1:0];
                mem_d     = CLEAR_VAL;
                cnt_nxt   = cnt + CNT_W'(1);
                if (cnt == LAST_ADDR) begin
                    state_nxt  = ST_IDLE;
                    last_write = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign cls_busy  = (state == ST_CLEAR);
    assign mem_raddr = scan_req ? scan_addr : draw_addr;
    assign scan_q    = mem_q;
    assign draw_q    = mem_q;

endmodule

// File: tb/tb_vram_ctrl.sv
// Randomized scoreboard bench for vram_ctrl with a behavioural VRAM and reference model.
module tb_vram_ctrl;
    import vram_ctrl_pkg::*;

    localparam int unsigned AW    = VRAM_ADDR_WIDTH;
    localparam int unsigned DW    = VRAM_DATA_WIDTH;
    localparam int unsigned DEPTH = VRAM_DEPTH;

    logic          clk = 1'b0;
    logic          rst, cls_req, scan_req, draw_req, draw_we;
    logic [AW-1:0] scan_addr, draw_addr;
    logic [DW-1:0] draw_d;
    logic          cls_busy, cls_done, scan_q_valid, draw_gnt, draw_q_valid, mem_we;
    logic [DW-1:0] scan_q, draw_q, mem_d, mem_q;
    logic [AW-1:0] mem_raddr, mem_waddr;

    logic [DW-1:0] vram    [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] scan_exp[$];
    logic [DW-1:0] draw_exp[$];

    int total = 0;
    int bad   = 0;
    bit busy = 1'b0, done_now = 1'b0, g_last = 1'b0;
    int clr_pos = 0;

    vram_ctrl dut (
        .clk(clk), .rst(rst), .cls_req(cls_req), .cls_busy(cls_busy), .cls_done(cls_done),
        .scan_req(scan_req), .scan_addr(scan_addr), .scan_q(scan_q), .scan_q_valid(scan_q_valid),
        .draw_req(draw_req), .draw_we(draw_we), .draw_addr(draw_addr), .draw_d(draw_d),
        .draw_gnt(draw_gnt), .draw_q(draw_q), .draw_q_valid(draw_q_valid),
        .mem_raddr(mem_raddr), .mem_q(mem_q), .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_d(mem_d)
    );

    always #5 clk = ~clk;

    // Behavioural dual-port VRAM, registered read, read-before-write.
    always @(posedge clk) begin
        if (mem_we) vram[mem_waddr] <= mem_d;
        mem_q <= vram[mem_raddr];
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Read-data monitor: pops the expectation queued when the read was issued.
    always @(negedge clk) begin
        if (scan_q_valid === 1'b1) begin
            if (scan_exp.size() == 0) chk("scan_valid_unexpected", 1, 0);
            else chk("scan_q", int'(scan_q), int'(scan_exp.pop_front()));
        end
        if (draw_q_valid === 1'b1) begin
            if (draw_exp.size() == 0) chk("draw_valid_unexpected", 1, 0);
            else chk("draw_q", int'(draw_q), int'(draw_exp.pop_front()));
        end
    end

    // One clock: check combinational/registered outputs against the model, advance the model.
    task automatic step();
        bit eg;
        bit done_next;
        #2;
        eg = draw_req && !busy && (draw_we || !scan_req);
        if (!rst) begin
            chk("draw_gnt", int'(draw_gnt), int'(eg));
            chk("cls_busy", int'(cls_busy), int'(busy));
            chk("cls_done", int'(cls_done), int'(done_now));
            chk("mem_raddr", int'(mem_raddr), scan_req ? int'(scan_addr) : int'(draw_addr));
            if (busy) begin
                chk("clr_we", int'(mem_we), 1);
                chk("clr_waddr", int'(mem_waddr), clr_pos);
                chk("clr_d", int'(mem_d), int'(CLS_VAL));
            end else begin
                chk("mem_we", int'(mem_we), int'(eg && draw_we));
                if (eg && draw_we) begin
                    chk("draw_waddr", int'(mem_waddr), int'(draw_addr));
                    chk("draw_wdata", int'(mem_d), int'(draw_d));
                end
            end
            if (scan_req) scan_exp.push_back(ref_mem[scan_addr]);
            if (eg && !draw_we) draw_exp.push_back(ref_mem[draw_addr]);
        end
        if (eg && draw_we) ref_mem[draw_addr] = draw_d;
        done_next = 1'b0;
        if (rst) begin
            busy = 1'b0;
        end else if (busy) begin
            ref_mem[clr_pos] = CLS_VAL;
            if (clr_pos == int'(DEPTH) - 1) begin
                busy = 1'b0;
                done_next = 1'b1;
            end else begin
                clr_pos++;
            end
        end else if (cls_req) begin
            busy = 1'b1;
            clr_pos = 0;
        end
        done_now = done_next;
        g_last = eg;
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        cls_req = 1'b0; scan_req = 1'b0; draw_req = 1'b0; draw_we = 1'b0;
    endtask

    task automatic readback();
        quiet();
        for (int a = 0; a < int'(DEPTH); a++) begin
            scan_req = 1'b1;
            scan_addr = AW'(a);
            step();
        end
        quiet();
        repeat (2) step();
    endtask

    task automatic wait_idle();
        int n = 0;
        quiet();
        while (busy && n < 3000) begin
            step();
            n++;
        end
        if (busy) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        for (int a = 0; a < int'(DEPTH); a++) begin
            vram[a] = DW'(3);
            ref_mem[a] = DW'(3);
        end
        rst = 1'b1; cls_req = 1'b1; scan_req = 1'b0; draw_req = 1'b0; draw_we = 1'b0;
        scan_addr = '0; draw_addr = '0; draw_d = '0;
        repeat (2) step();
        rst = 1'b0; cls_req = 1'b0;
        chk("rst_scan_valid", int'(scan_q_valid), 0);
        chk("rst_draw_valid", int'(draw_q_valid), 0);
        step();
        step();

        // Full clear over a preloaded memory, with scan traffic, a held draw write and a stray cls_req.
        cls_req = 1'b1;
        step();
        cls_req = 1'b0;
        draw_req = 1'b1; draw_we = 1'b1; draw_addr = AW'(5); draw_d = DW'(2);
        begin
            int n = 0;
            while (1) begin
                scan_req = 1'($urandom_range(0, 1));
                scan_addr = AW'($urandom);
                cls_req = (n == 1000);
                step();
                n++;
                if (g_last) break;
                if (n > 3000) begin
                    chk("draw_wait_timeout", 0, 1);
                    break;
                end
            end
            chk("draw_grant_cycle", n, int'(DEPTH) + 1);
        end
        readback();

        // Scan blocks a draw read; the read is granted once scan releases the port.
        scan_req = 1'b1; scan_addr = AW'('h040);
        draw_req = 1'b1; draw_we = 1'b0; draw_addr = AW'('h7FF);
        step();
        scan_req = 1'b0;
        step();
        quiet();
        step();

        // Same-address draw write and scan read returns the old word.
        draw_req = 1'b1; draw_we = 1'b1; draw_addr = AW'('h100); draw_d = DW'(2);
        step();
        draw_d = DW'(1); scan_req = 1'b1; scan_addr = AW'('h100);
        step();
        draw_req = 1'b0;
        step();
        quiet();
        step();

        // Randomized mixed traffic with held draw requests.
        begin
            bit pend = 1'b0;
            for (int i = 0; i < 600; i++) begin
                if (!pend && $urandom_range(0, 2) == 0) begin
                    pend = 1'b1;
                    draw_we = 1'($urandom_range(0, 1));
                    draw_addr = AW'($urandom);
                    draw_d = DW'($urandom);
                end
                draw_req = pend;
                scan_req = 1'($urandom_range(0, 1));
                scan_addr = AW'($urandom);
                cls_req = ($urandom_range(0, 299) == 0);
                step();
                if (g_last) pend = 1'b0;
            end
        end
        wait_idle();

        // Refill with 3, then abort a clear by reset at T+500.
        for (int a = 0; a < int'(DEPTH); a++) begin
            draw_req = 1'b1; draw_we = 1'b1; draw_addr = AW'(a); draw_d = DW'(3);
            step();
        end
        draw_addr = AW'(600); draw_d = DW'(1); cls_req = 1'b1;
        step();
        quiet();
        repeat (499) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (4) step();
        readback();

        quiet();
        repeat (3) step();
        chk("scan_queue_drained", scan_exp.size(), 0);
        chk("draw_queue_drained", draw_exp.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
